mram_rd_checker: RTL and testbench
==================================

// Module: mram_rd_checker
// PURPOSE
//   Read-side companion to the Mram write stimulus. On start, sweeps every RAM
//   address once, compares rddata against the writer's incrementing pattern,
//   and reports error count, first failing address and pass/fail.
//   Sits on the RAM read port; single clock domain (RAM read clock).
// PARAMETERS
//   DATA_W        32  RAM data width
//   ADDR_W        5   RAM address width; sweep covers 2**ADDR_W locations
//   RD_LAT        1   RAM read latency in cycles, rd_en to rddata valid (1..4)
//   PATTERN_BASE  1   expected data at address 0; expected(a) = PATTERN_BASE + a
// PORTS
//   clk             in   1        clock, rising edge
//   rst             in   1        asynchronous reset, active-high
//   start           in   1        1-cycle pulse: begin sweep (ignored while busy)
//   rdaddr          out  ADDR_W   RAM read address
//   rd_en           out  1        RAM read enable
//   rddata          in   DATA_W   RAM read data, valid RD_LAT cycles after rd_en
//   busy            out  1        high from cycle after start until done
//   done            out  1        1-cycle pulse at end of sweep
//   pass            out  1        1 when last sweep had zero errors; held
//   err_cnt         out  ADDR_W+1 mismatches in last/current sweep
//   first_err_addr  out  ADDR_W   address of first mismatch
//   first_err_vld   out  1        first_err_addr is valid
// BEHAVIOUR
//   Reset: state IDLE; rdaddr=0, rd_en=0, busy=0, done=0, pass=0, err_cnt=0,
//     first_err_addr=0, first_err_vld=0, compare pipeline cleared. Async
//     assertion takes effect immediately, including mid-sweep (rd_en drops).
//   FSM: IDLE -> READ -> DRAIN -> DONE -> IDLE.
//   IDLE: start=1 -> READ next cycle; on that edge err_cnt, first_err_vld,
//     pass cleared, rdaddr=0.
//   READ: rd_en=1 every cycle, rdaddr increments by 1 per cycle from 0 to
//     2**ADDR_W-1 (no gaps). After issuing last address -> DRAIN.
//   DRAIN: rd_en=0; waits RD_LAT cycles so last read data is compared -> DONE.
//   DONE: done=1 for exactly one cycle; pass=(err_cnt==0) registered and held
//     until next start; -> IDLE. rdaddr wraps to 0.
//   busy=1 in READ, DRAIN, DONE-entry; busy=0 in IDLE (done and busy never
//     both 1 except on the DONE cycle, where busy=0).
//   Compare pipeline: RD_LAT-deep shift of {rd_en, rdaddr}. When delayed
//     valid=1, expected = (PATTERN_BASE + delayed addr) mod 2**DATA_W, addr
//     zero-extended. Mismatch -> err_cnt += 1 (max 2**ADDR_W, fits, no wrap).
//     First mismatch of sweep latches first_err_addr, sets first_err_vld.
//   start during READ/DRAIN/DONE ignored; no restart, no counter clear.
//   Total sweep latency: start to done = 2**ADDR_W + RD_LAT + 1 cycles.
//   rddata is don't-care when delayed valid=0 (X not propagated to err_cnt).
// TESTING
//   1 Reset, then RAM preloaded with a+1, RD_LAT=1, start pulse -> rd_en high
//     32 cycles, addrs 0..31, done at start+34, pass=1, err_cnt=0, vld=0.
//   2 RAM word 7 corrupted to 0xDEADBEEF -> err_cnt=1, first_err_addr=7,
//     first_err_vld=1, pass=0.
//   3 Words 3, 20, 31 corrupted -> err_cnt=3, first_err_addr=3; all 32 words
//     corrupted -> err_cnt=32 (no wrap), first_err_addr=0.
//   4 start re-pulsed at sweep cycle 10 -> ignored, single done, addr sequence
//     unbroken; a second start after done clears err_cnt and repeats sweep.
//   5 rst asserted mid-READ at rdaddr=12 -> rd_en=0, rdaddr=0, busy=0,
//     err_cnt=0 immediately; no done pulse; next start sweeps cleanly.
//   6 RD_LAT=3, PATTERN_BASE=32'hFFFF_FFFF -> expected wraps (addr1 = 0);
//     clean RAM gives pass=1, done at start+2**ADDR_W+4.

Source files
------------

// File: rtl/mram_rd_checker.sv
// Read-side RAM checker: sweeps every address once after start, compares read data
// against the incrementing write pattern and reports error count, first failing address and pass.
module mram_rd_checker #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ADDR_W       = 5,
  parameter int unsigned       RD_LAT       = 1,
  parameter logic [DATA_W-1:0] PATTERN_BASE = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rdaddr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rddata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_vld
);

  localparam int unsigned       CNT_W     = 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rdaddr_nxt;
  logic              rd_en_nxt, busy_nxt, done_nxt, start_ok;
  logic [CNT_W-1:0]  drain_cnt, drain_cnt_nxt;

  logic              pipe_vld  [RD_LAT];
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];
  logic [DATA_W-1:0] expected;
  logic              hit;
  logic [ADDR_W:0]   err_cnt_nxt;

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_nxt     = state;
    rdaddr_nxt    = rdaddr;
    rd_en_nxt     = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    drain_cnt_nxt = drain_cnt;
    start_ok      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_nxt  = READ;
          rdaddr_nxt = '0;
          rd_en_nxt  = 1'b1;
          busy_nxt   = 1'b1;
        end
      end
      READ: begin
        busy_nxt = 1'b1;
        if (rdaddr == LAST_ADDR) begin
          state_nxt     = DRAIN;
          rdaddr_nxt    = '0;
          drain_cnt_nxt = CNT_W'(RD_LAT - 1);
        end else begin
          rd_en_nxt  = 1'b1;
          rdaddr_nxt = rdaddr + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          busy_nxt      = 1'b1;
          drain_cnt_nxt = drain_cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rdaddr    <= '0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rdaddr    <= rdaddr_nxt;
      rd_en     <= rd_en_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Delay {rd_en, rdaddr} by the RAM latency so each word meets its own address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= rd_en;
      pipe_addr[0] <= rdaddr;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  always_comb begin
    expected    = PATTERN_BASE + DATA_W'(pipe_addr[RD_LAT-1]);
    hit         = pipe_vld[RD_LAT-1] && (rddata != expected);
    err_cnt_nxt = start_ok ? '0 : err_cnt + (ADDR_W+1)'(hit);
  end

  // Result registers; pass is judged on the count including the final compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_vld  <= 1'b0;
      pass           <= 1'b0;
    end else begin
      err_cnt <= err_cnt_nxt;
      if (start_ok) begin
        first_err_vld <= 1'b0;
        pass          <= 1'b0;
      end else begin
        if (hit && !first_err_vld) begin
          first_err_addr <= pipe_addr[RD_LAT-1];
          first_err_vld  <= 1'b1;
        end
        if (done_nxt) pass <= (err_cnt_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_mram_rd_checker.sv
// Scoreboard bench for mram_rd_checker: two instances (latency 1 / base 1 and
// latency 3 / base 0xFFFFFFFF) fed by behavioural RAM models.
module tb_mram_rd_checker;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned N  = 32;

  typedef struct {
    int unsigned inst;
    int unsigned scyc;
    int unsigned errs;
    bit          vld;
    int unsigned faddr;
  } exp_t;

  logic          clk = 1'b0;
  int unsigned   cyc = 0;
  logic          rst     [2];
  logic          start   [2];
  logic          rd_en   [2];
  logic          busy    [2];
  logic          done    [2];
  logic          pass    [2];
  logic          vld     [2];
  logic [AW-1:0] rdaddr  [2];
  logic [AW-1:0] faddr   [2];
  logic [AW:0]   err_cnt [2];
  logic [DW-1:0] rddata  [2];
  logic [DW-1:0] mem     [2][N];

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] base_of(input int g);
    return (g == 0) ? 32'd1 : 32'hFFFF_FFFF;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int unsigned       LAT  = (g == 0) ? 1 : 3;
    localparam logic [DW-1:0]     BASE = (g == 0) ? 32'd1 : 32'hFFFF_FFFF;
    logic [DW-1:0] rp [3];
    int unsigned   exp_addr = 0;
    int unsigned   rd_cnt   = 0;
    bit            pend_pass = 0;
    bit            pend_val  = 0;

    mram_rd_checker #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT), .PATTERN_BASE(BASE)) dut (
      .clk(clk), .rst(rst[g]), .start(start[g]), .rdaddr(rdaddr[g]), .rd_en(rd_en[g]),
      .rddata(rddata[g]), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
      .err_cnt(err_cnt[g]), .first_err_addr(faddr[g]), .first_err_vld(vld[g])
    );

    // RAM model: registered read, garbage when not enabled.
    always @(posedge clk) begin
      rp[0] <= rd_en[g] ? mem[g][rdaddr[g]] : $urandom;
      rp[1] <= rp[0];
      rp[2] <= rp[1];
    end
    assign rddata[g] = rp[LAT-1];

    always @(negedge clk) begin : mon
      exp_t e;
      if (rst[g]) begin
        exp_addr  = 0;
        rd_cnt    = 0;
        pend_pass = 0;
      end else begin
        if (pend_pass) begin
          check($sformatf("pass_held%0d", g), longint'(pass[g]), longint'(pend_val));
          pend_pass = 0;
        end
        if (rd_en[g]) begin
          check($sformatf("rdaddr%0d", g), longint'(rdaddr[g]), longint'(exp_addr));
          exp_addr = (exp_addr + 1) % N;
          rd_cnt++;
        end
        if (done[g]) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done%0d: got done=1, expected no done (cycle %0d)", g, cyc);
          end else begin
            e = sb.pop_front();
            check($sformatf("done_inst%0d", g), longint'(g), longint'(e.inst));
            check($sformatf("latency%0d", g), longint'(cyc - e.scyc), longint'(N + LAT + 1));
            check($sformatf("reads%0d", g), longint'(rd_cnt), longint'(N));
            check($sformatf("err_cnt%0d", g), longint'(err_cnt[g]), longint'(e.errs));
            check($sformatf("first_vld%0d", g), longint'(vld[g]), longint'(e.vld));
            if (e.vld) check($sformatf("first_addr%0d", g), longint'(faddr[g]), longint'(e.faddr));
            check($sformatf("busy_at_done%0d", g), longint'(busy[g]), 0);
            pend_pass = 1;
            pend_val  = (e.errs == 0);
          end
          rd_cnt = 0;
        end
      end
    end
  end

  task automatic clean(input int g);
    for (int a = 0; a < N; a++) mem[g][a] = base_of(g) + 32'(a);
  endtask

  // Reference: count words that differ from base+addr (mod 2**32).
  task automatic push_exp(input int g, input int unsigned scyc);
    exp_t e;
    e.inst = g; e.scyc = scyc; e.errs = 0; e.vld = 0; e.faddr = 0;
    for (int a = 0; a < N; a++) begin
      if (mem[g][a] != base_of(g) + 32'(a)) begin
        if (!e.vld) begin e.vld = 1; e.faddr = a; end
        e.errs++;
      end
    end
    sb.push_back(e);
  endtask

  task automatic pulse_start(input int g, input bit accept);
    @(posedge clk); #1;
    start[g] = 1'b1;
    if (accept) push_exp(g, cyc);
    @(posedge clk); #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done[g]) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout%0d: got no done in 200 cycles, expected done", g);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic sweep(input int g);
    pulse_start(g, 1);
    wait_done(g);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < 2; g++) begin rst[g] = 1'b1; start[g] = 1'b0; clean(g); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_rd_en%0d", g), longint'(rd_en[g]), 0);
      check($sformatf("rst_rdaddr%0d", g), longint'(rdaddr[g]), 0);
      check($sformatf("rst_busy%0d", g), longint'(busy[g]), 0);
      check($sformatf("rst_done%0d", g), longint'(done[g]), 0);
      check($sformatf("rst_pass%0d", g), longint'(pass[g]), 0);
      check($sformatf("rst_err%0d", g), longint'(err_cnt[g]), 0);
      check($sformatf("rst_vld%0d", g), longint'(vld[g]), 0);
      check($sformatf("rst_faddr%0d", g), longint'(faddr[g]), 0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Clean sweep, then single, multiple and total corruption.
    sweep(0);
    mem[0][7] = 32'hDEAD_BEEF;
    sweep(0);
    clean(0);
    mem[0][3] = 32'h0; mem[0][20] = 32'h5; mem[0][31] = 32'hFFFF_0000;
    sweep(0);
    for (int a = 0; a < N; a++) mem[0][a] = ~(base_of(0) + 32'(a));
    sweep(0);

    // Restart during READ is ignored; a later start clears the count.
    clean(0);
    mem[0][5] = 32'h1234; mem[0][9] = 32'h0;
    pulse_start(0, 1);
    repeat (8) @(posedge clk);
    pulse_start(0, 0);
    wait_done(0);
    sweep(0);

    // Asynchronous reset mid-READ.
    clean(0);
    mem[0][3] = 32'h0;
    pulse_start(0, 1);
    begin
      bit hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (rd_en[0] && rdaddr[0] == 5'd12) hit = 1;
      end
      check("reach_addr12", longint'(hit), 1);
    end
    check("pre_rst_err", longint'(err_cnt[0]), 1);
    #1 rst[0] = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_rd_en", longint'(rd_en[0]), 0);
    check("mid_rst_rdaddr", longint'(rdaddr[0]), 0);
    check("mid_rst_busy", longint'(busy[0]), 0);
    check("mid_rst_err", longint'(err_cnt[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst[0] = 1'b0;
    clean(0);
    sweep(0);

    // Latency 3 with wrapping pattern base.
    sweep(1);
    mem[1][1] = 32'h1;
    sweep(1);

    // Randomised corruption on both instances.
    for (int r = 0; r < 8; r++) begin
      int g = r % 2;
      clean(g);
      for (int a = 0; a < N; a++)
        if ($urandom_range(0, 4) == 0) mem[g][a] = $urandom;
      sweep(g);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
